// File: rtl/tlu_trig_sched_if.sv
// tlu_trig_sched_if: request/trigger handshake bundle between the local trigger sources and the scheduler.
// Latency: none, wires only.
// Backpressure: carried by i_tx_ready; the slave modport is the scheduler view, master is the source/transmitter side.
// Signals: enable, req, port_mask, conf_gap, id_clear, tx_ready, tx_time_out in; trig, trig_id, grant, busy, counters out.
interface tlu_trig_sched_if #(
    parameter int N_PORTS = 4,
    parameter int CNT_W   = 16
);
    logic               i_enable;
    logic [N_PORTS-1:0] i_req;
    logic [N_PORTS-1:0] i_port_mask;
    logic [15:0]        i_conf_gap;
    logic               i_id_clear;
    logic               i_tx_ready;
    logic               i_tx_time_out;
    logic               o_trig;
    logic [30:0]        o_trig_id;
    logic [N_PORTS-1:0] o_grant;
    logic               o_busy;
    logic [CNT_W-1:0]   o_accept_cnt;
    logic [CNT_W-1:0]   o_skip_cnt;
    logic [CNT_W-1:0]   o_timeout_cnt;

    modport master (
        output i_enable, i_req, i_port_mask, i_conf_gap, i_id_clear, i_tx_ready, i_tx_time_out,
        input  o_trig, o_trig_id, o_grant, o_busy, o_accept_cnt, o_skip_cnt, o_timeout_cnt
    );

    modport slave (
        input  i_enable, i_req, i_port_mask, i_conf_gap, i_id_clear, i_tx_ready, i_tx_time_out,
        output o_trig, o_trig_id, o_grant, o_busy, o_accept_cnt, o_skip_cnt, o_timeout_cnt
    );
endinterface

// File: rtl/tlu_trig_sched.sv
// tlu_trig_sched: round-robin scheduler of local trigger requests onto the TLU transmitter, owns the 31-bit trigger ID.
// Latency: REQ driven high before edge k gives TRIG during the cycle after edge k+2 (edge reg, pending flag, ISSUE).
// Backpressure: one trigger in flight; engine waits for i_tx_ready plus conf_gap idle cycles, repeat edges on a pending port are skipped.
// Ports: i_sys_clk, i_sys_rst (async, active high), io_sched (slave view of tlu_trig_sched_if).
module tlu_trig_sched #(
    parameter int N_PORTS = 4,
    parameter int CNT_W   = 16
) (
    input  logic            i_sys_clk,
    input  logic            i_sys_rst,
    tlu_trig_sched_if.slave io_sched
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD1, S_HOLD2, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_PORTS-1:0] r_req_cur, r_req_prev, r_pend, r_grant;
    logic [PW-1:0]      r_ptr, r_win;
    logic [15:0]        r_gap;
    logic [30:0]        r_id_cnt, r_trig_id;
    logic [CNT_W-1:0]   r_acc_cnt, r_skip_cnt, r_tmo_cnt;

    logic [N_PORTS-1:0] w_edge, w_live, w_set, w_issue_clr, w_skip_vec, w_pend_nxt, w_win_oh;
    logic [3:0]         w_skip_n;
    logic [CNT_W:0]     w_skip_sum;
    logic [PW-1:0]      w_win;
    logic               w_found, w_start, w_trig, w_busy;
    int                 w_idx;

    assign w_edge = r_req_cur & ~r_req_prev;
    // A port masked this cycle must not win even though its flag clears only next cycle.
    assign w_live = r_pend & ~io_sched.i_port_mask;

    // Round-robin search starting at the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
            if (!w_found && w_live[PW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    assign w_start = (r_state == S_IDLE) && io_sched.i_enable && w_found &&
                     io_sched.i_tx_ready && (r_gap == 16'd0);

    // Pending flags and skip detection. The winner's flag is treated as already
    // cleared during ISSUE, so a coincident edge re-arms it without a skip.
    always_comb begin
        w_issue_clr = (r_state == S_ISSUE) ? r_grant : '0;
        w_set       = io_sched.i_enable ? (w_edge & ~io_sched.i_port_mask) : '0;
        w_skip_vec  = w_set & r_pend & ~w_issue_clr;
        w_pend_nxt  = ((r_pend & ~w_issue_clr) | w_set) & ~io_sched.i_port_mask;
        if (!io_sched.i_enable && (r_state == S_IDLE)) w_pend_nxt = '0;
        w_skip_n = 4'd0;
        for (int i = 0; i < N_PORTS; i++) w_skip_n = w_skip_n + {3'b000, w_skip_vec[i]};
        w_skip_sum = {1'b0, r_skip_cnt} + (CNT_W+1)'(w_skip_n);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_start) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_trig      = 1'b1;
                w_state_nxt = S_HOLD1;
            end
            // Transmitter READY is still falling here; it is not looked at.
            S_HOLD1: w_state_nxt = S_HOLD2;
            S_HOLD2: w_state_nxt = S_WAIT;
            S_WAIT:  if (io_sched.i_tx_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_req_cur  <= '0;
            r_req_prev <= '0;
            r_pend     <= '0;
        end else begin
            r_req_cur  <= io_sched.i_req;
            r_req_prev <= r_req_cur;
            r_pend     <= w_pend_nxt;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_grant   <= '0;
            r_win     <= '0;
            r_ptr     <= '0;
            r_trig_id <= '0;
            r_id_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_grant   <= w_win_oh;
                r_win     <= w_win;
                // A clear in the launch cycle already applies to this trigger.
                r_trig_id <= io_sched.i_id_clear ? 31'd0 : r_id_cnt;
            end
            if (r_state == S_ISSUE)
                r_ptr <= (int'(r_win) == N_PORTS - 1) ? '0 : r_win + PW'(1);
            if (io_sched.i_id_clear)
                r_id_cnt <= 31'd0;
            else if (r_state == S_ISSUE)
                r_id_cnt <= r_id_cnt + 31'd1;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_gap <= 16'd0;
        end else if ((r_state == S_WAIT) && io_sched.i_tx_ready) begin
            r_gap <= io_sched.i_conf_gap;
        end else if ((r_state == S_IDLE) && (r_gap != 16'd0)) begin
            r_gap <= r_gap - 16'd1;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_acc_cnt  <= '0;
            r_skip_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if ((r_state == S_ISSUE) && (r_acc_cnt != CNT_MAX))
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            if ((r_state == S_WAIT) && io_sched.i_tx_time_out && (r_tmo_cnt != CNT_MAX))
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            r_skip_cnt <= w_skip_sum[CNT_W] ? CNT_MAX : w_skip_sum[CNT_W-1:0];
        end
    end

    assign io_sched.o_trig        = w_trig;
    assign io_sched.o_grant       = w_trig ? r_grant : '0;
    assign io_sched.o_busy        = w_busy;
    assign io_sched.o_trig_id     = r_trig_id;
    assign io_sched.o_accept_cnt  = r_acc_cnt;
    assign io_sched.o_skip_cnt    = r_skip_cnt;
    assign io_sched.o_timeout_cnt = r_tmo_cnt;
endmodule

// File: tb/tb_tlu_trig_sched.sv
// tb_tlu_trig_sched: directed and randomized bench for tlu_trig_sched with a queue/pointer level reference model.
// Latency: n/a.
// Backpressure: bench plays the transmitter by driving tx_ready / tx_time_out.
module tb_tlu_trig_sched;
    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlu_trig_sched_if #(.N_PORTS(NP), .CNT_W(CW)) bus ();
    tlu_trig_sched #(.N_PORTS(NP), .CNT_W(CW)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .io_sched  (bus)
    );

    int ntrig = 0;
    always @(negedge clk) if (bus.o_trig === 1'b1) ntrig <= ntrig + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state: next-search pointer, next ID, event totals.
    int          m_ptr, m_acc, m_skip, m_tmo;
    logic [30:0] m_id;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int rr_pick(input logic [3:0] s, input int p);
        logic [1:0] ix;
        for (int k = 0; k < NP; k++) begin
            ix = 2'((p + k) % NP);
            if (s[ix]) return int'(ix);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_id = '0; m_acc = 0; m_skip = 0; m_tmo = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] v, input int w);
        bus.i_req = v;
        step(w);
        bus.i_req = '0;
    endtask

    // Waits (bounded) for TRIG, then checks grant and ID against the model.
    task automatic expect_trig(input string tag, input int port, output int n);
        logic [3:0] oh;
        n = 0;
        while (bus.o_trig !== 1'b1 && n < 100) begin step(1); n++; end
        chk({tag, "_seen"}, 64'(bus.o_trig), 64'd1);
        oh = 4'b0001 << port;
        chk({tag, "_grant"}, 64'(bus.o_grant), 64'(oh));
        chk({tag, "_id"}, 64'(bus.o_trig_id), 64'(m_id));
        m_id  = m_id + 31'd1;
        m_acc = m_acc + 1;
        m_ptr = (port + 1) % NP;
    endtask

    task automatic serve_set(input string tag, input logic [3:0] s);
        logic [3:0] rem;
        int p, n;
        rem = s;
        while (rem != 4'd0) begin
            p = rr_pick(rem, m_ptr);
            expect_trig(tag, p, n);
            rem[2'(p)] = 1'b0;
            step(1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.o_busy !== 1'b0 && n < 200) begin step(1); n++; end
        chk({tag, "_idle"}, 64'(bus.o_busy), 64'd0);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_acc"},  64'(bus.o_accept_cnt),  64'(sat(m_acc)));
        chk({tag, "_skip"}, 64'(bus.o_skip_cnt),    64'(sat(m_skip)));
        chk({tag, "_tmo"},  64'(bus.o_timeout_cnt), 64'(sat(m_tmo)));
    endtask

    initial begin
        int n, n0;
        logic [30:0] exp_id;
        logic [3:0] s, msk;

        bus.i_enable = 1'b0; bus.i_req = '0; bus.i_port_mask = '0; bus.i_conf_gap = '0;
        bus.i_id_clear = 1'b0; bus.i_tx_ready = 1'b0; bus.i_tx_time_out = 1'b0;
        model_reset();
        step(2);
        chk("rst_trig", 64'(bus.o_trig), 64'd0);
        chk("rst_grant", 64'(bus.o_grant), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_id", 64'(bus.o_trig_id), 64'd0);
        chk_cnts("rst");
        rst = 1'b0;
        bus.i_enable = 1'b1; bus.i_tx_ready = 1'b1;
        step(2);

        // Single request: exact three-stage latency, one-cycle pulse, ID increments.
        bus.i_req = 4'b0001; step(1); bus.i_req = '0;
        step(1);
        chk("t1_lat_early", 64'(bus.o_trig), 64'd0);
        step(1);
        chk("t1_lat", 64'(bus.o_trig), 64'd1);
        expect_trig("t1", 0, n);
        chk("t1_busy", 64'(bus.o_busy), 64'd1);
        step(1);
        chk("t1_pulse", 64'(bus.o_trig), 64'd0);
        chk("t1_acc1", 64'(bus.o_accept_cnt), 64'd1);
        wait_idle("t1");
        pulse(4'b0001, 1); expect_trig("t1b", 0, n); step(1);
        wait_idle("t1b");
        chk_cnts("t1");

        // Fairness from a fresh pointer, then pointer continuation.
        step(1); rst = 1'b1; step(1); rst = 1'b0; model_reset();
        bus.i_req = 4'b1111;
        serve_set("t2", 4'b1111);
        bus.i_req = '0;
        wait_idle("t2");
        chk_cnts("t2");
        pulse(4'b0101, 1);
        serve_set("t3", 4'b0101);
        wait_idle("t3");

        // Skips while parked in WAIT; gap 0 issues in the first IDLE cycle.
        pulse(4'b0010, 1); expect_trig("t4", 1, n);
        bus.i_tx_ready = 1'b0;
        step(4);
        repeat (3) begin pulse(4'b0010, 1); step(2); end
        step(2);
        m_skip = m_skip + 2;
        chk("t4_skip", 64'(bus.o_skip_cnt), 64'(sat(m_skip)));
        n0 = ntrig;
        bus.i_tx_ready = 1'b1;
        expect_trig("t4b", 1, n);
        chk("t4_gap0", 64'(n), 64'd2);
        step(1); wait_idle("t4"); step(20);
        chk("t4_one_trig", 64'(ntrig - n0), 64'd1);
        chk_cnts("t4");

        // Programmable gap: READY return to next TRIG is conf_gap + 2 cycles.
        bus.i_conf_gap = 16'd10;
        pulse(4'b1000, 1); expect_trig("t5", 3, n);
        bus.i_tx_ready = 1'b0;
        step(1); pulse(4'b0001, 1); step(5);
        bus.i_tx_ready = 1'b1;
        expect_trig("t5b", 0, n);
        chk("t5_gap", 64'(n), 64'd12);
        bus.i_conf_gap = 16'd0;
        step(1); wait_idle("t5"); step(12);

        // Timeouts and saturating skip/timeout counters, no trigger while in WAIT.
        pulse(4'b0010, 1); expect_trig("t6", 1, n);
        bus.i_tx_ready = 1'b0;
        step(4);
        n0 = ntrig;
        repeat (2) begin bus.i_tx_time_out = 1'b1; step(1); bus.i_tx_time_out = 1'b0; step(2); end
        m_tmo = m_tmo + 2;
        chk("t6_tmo2", 64'(bus.o_timeout_cnt), 64'd2);
        repeat (5) begin pulse(4'b1111, 1); step(2); end
        step(2);
        m_skip = m_skip + 16;
        repeat (16) begin bus.i_tx_time_out = 1'b1; step(1); bus.i_tx_time_out = 1'b0; step(1); end
        m_tmo = m_tmo + 16;
        chk("t6_no_trig", 64'(ntrig - n0), 64'd0);
        chk_cnts("t6");
        bus.i_tx_ready = 1'b1;
        serve_set("t6s", 4'b1111);
        wait_idle("t6");

        // ID wrap and ID_CLEAR coincident with ISSUE.
        force dut.r_id_cnt = 31'h7FFFFFFF;
        #1;
        release dut.r_id_cnt;
        m_id = 31'h7FFFFFFF;
        step(1);
        pulse(4'b0001, 1); expect_trig("t7a", 0, n); step(1); wait_idle("t7a");
        pulse(4'b0001, 1); expect_trig("t7b", 0, n); step(1); wait_idle("t7b");
        exp_id = m_id;
        pulse(4'b0100, 1); expect_trig("t7c", 2, n);
        bus.i_id_clear = 1'b1; step(1); bus.i_id_clear = 1'b0;
        m_id = '0;
        chk("t7_id_held", 64'(bus.o_trig_id), 64'(exp_id));
        wait_idle("t7c");
        pulse(4'b0100, 1); expect_trig("t7d", 2, n); step(1); wait_idle("t7d");
        chk_cnts("t7");

        // ENABLE: low in IDLE drops flags and blocks capture; low mid-sequence does not abort.
        bus.i_tx_ready = 1'b0;
        pulse(4'b0001, 1); step(3);
        bus.i_enable = 1'b0; step(2); bus.i_enable = 1'b1;
        n0 = ntrig; bus.i_tx_ready = 1'b1; step(15);
        chk("t8_en_clear", 64'(ntrig - n0), 64'd0);
        bus.i_enable = 1'b0; pulse(4'b0010, 1); step(3); bus.i_enable = 1'b1; step(15);
        chk("t8_en_ignore", 64'(ntrig - n0), 64'd0);
        pulse(4'b0001, 1); expect_trig("t8", 0, n);
        bus.i_enable = 1'b0; step(1);
        chk("t8_no_abort", 64'(bus.o_busy), 64'd1);
        wait_idle("t8"); bus.i_enable = 1'b1;
        chk_cnts("t8");

        // Masking: masked edges ignored, masking a pending port drops it.
        bus.i_port_mask = 4'b0100;
        n0 = ntrig;
        repeat (3) begin pulse(4'b0100, 1); step(2); end
        step(10);
        chk("t9_masked", 64'(ntrig - n0), 64'd0);
        bus.i_port_mask = 4'b0000;
        pulse(4'b0001, 1); expect_trig("t9", 0, n);
        bus.i_tx_ready = 1'b0; step(4);
        pulse(4'b0100, 1); step(3);
        bus.i_port_mask = 4'b0100; step(2);
        n0 = ntrig; bus.i_tx_ready = 1'b1; step(20);
        chk("t9_mask_drop", 64'(ntrig - n0), 64'd0);
        bus.i_port_mask = 4'b0000;
        chk_cnts("t9");

        // Asynchronous reset while parked in WAIT with a pending flag.
        pulse(4'b0001, 1); expect_trig("t10", 0, n);
        bus.i_tx_ready = 1'b0; step(4);
        pulse(4'b0010, 1); step(3);
        #2; rst = 1'b1; #1;
        chk("t10_busy", 64'(bus.o_busy), 64'd0);
        chk("t10_id", 64'(bus.o_trig_id), 64'd0);
        model_reset();
        chk_cnts("t10");
        @(negedge clk); rst = 1'b0; bus.i_tx_ready = 1'b1;
        n0 = ntrig; step(20);
        chk("t10_no_trig", 64'(ntrig - n0), 64'd0);

        // Randomized bursts: simultaneous edges on a random set, random gap/mask/width.
        for (int it = 0; it < 25; it++) begin
            msk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            s   = 4'($urandom_range(1, 15));
            bus.i_port_mask = msk;
            bus.i_conf_gap  = 16'($urandom_range(0, 4));
            step(1);
            n0 = ntrig;
            pulse(s, $urandom_range(1, 3));
            if ((s & ~msk) == 4'd0) begin
                step(10);
                chk("rand_none", 64'(ntrig - n0), 64'd0);
            end else begin
                serve_set("rand", s & ~msk);
            end
            wait_idle("rand");
            step(6);
        end
        bus.i_port_mask = '0;
        chk_cnts("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlu_trig_sched.md
Name: tlu_trig_sched

Overview:
- Schedules trigger requests from up to N_PORTS local sources, such as DUT ports and the internal pulser, onto the single trigger/handshake interface of the TLU transmitter.
- Uses round-robin arbitration, owns the 31-bit trigger ID counter, and paces triggers with a programmable inter-trigger gap.
- Counts accepted, skipped and timed-out triggers.
- Sits between the request sources and the TLU transmitter, in the SYS_CLK domain.

Parameters:
N_PORTS, 4, number of requesters (1..8)
CNT_W, 16, width of statistics counters

Ports:
SYS_CLK  in  1  system clock; single clock domain
SYS_RST  in  1  asynchronous, active-high reset
ENABLE  in  1  scheduler enable
REQ  in  N_PORTS  per-port trigger request, level; rising edge detected internally
PORT_MASK  in  N_PORTS  1 = port disabled
CONF_GAP  in  16  minimum idle SYS_CLK cycles between READY return and next TRIG
ID_CLEAR  in  1  one-cycle pulse: clear trigger ID counter
TX_READY  in  1  transmitter READY
TX_TIME_OUT  in  1  transmitter TIME_OUT pulse
TRIG  out  1  one-cycle trigger pulse to transmitter
TRIG_ID  out  31  ID accompanying TRIG; stable until next TRIG
GRANT  out  N_PORTS  one-hot, pulses together with TRIG
BUSY  out  1  high in every state except IDLE
ACCEPT_CNT  out  CNT_W  triggers issued
SKIP_CNT  out  CNT_W  requests dropped
TIMEOUT_CNT  out  CNT_W  transmitter timeouts

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - TRIG, GRANT, BUSY = 0.
  - TRIG_ID = 0.
  - All counters = 0.
  - Pending flags = 0.
  - Round-robin pointer = 0.
  - Gap counter = 0.
  - REQ edge registers = 0.
- Request capture:
  - REQ is registered once per port; an edge is prev=0 and cur=1.
  - An edge on an unmasked port sets that port's pending flag.
  - An edge while the flag is already set increments SKIP_CNT once per such edge. Several ports in the same cycle add their count.
  - Edges on masked ports are ignored; they are not counted.
  - Setting a mask bit clears that port's pending flag on the next cycle.
  - While ENABLE = 0, no flags are set and no skips are counted.
- Arbitration:
  - Round-robin. Search starts at the pointer and wraps modulo N_PORTS.
  - The first pending port wins.
  - After a grant, pointer = winner + 1 mod N_PORTS.
- State machine, one transition per cycle:
  - IDLE: if ENABLE and any flag pending and TX_READY and gap counter == 0, go to ISSUE.
  - ISSUE (one cycle):
    - TRIG = 1, GRANT = onehot(winner).
    - Winner's flag is cleared. If a new edge arrives on the winner in the same cycle, the flag stays set; no skip.
    - TRIG_ID presents the current ID counter value.
    - After ISSUE, the ID counter increments (wrapping 2^31-1 -> 0) and ACCEPT_CNT increments.
    - Go to HOLD.
  - HOLD: 2 cycles; TX_READY is ignored while the transmitter's READY deasserts. Then go to WAIT.
  - WAIT:
    - If TX_TIME_OUT = 1: TIMEOUT_CNT increments; the state remains WAIT.
    - If TX_READY = 1: load the gap counter with CONF_GAP and go to IDLE.
  - The gap counter decrements to 0 in IDLE.
  - CONF_GAP = 0 allows ISSUE in the first IDLE cycle after WAIT.
- Latency:
  - REQ rising at cycle t (registered) with the engine idle and ready gives TRIG at t+3: edge register, pending flag, ISSUE.
- ENABLE:
  - Deasserting ENABLE outside IDLE does not abort; the sequence completes to IDLE.
  - ENABLE = 0 in IDLE clears all pending flags.
- ID_CLEAR:
  - Sets the ID counter to 0. Applied after any increment in the same cycle; clear wins.
  - Does not alter the TRIG_ID output until the next ISSUE.
- Counters: all saturate at 2^CNT_W-1; they never wrap.

Test Plan:
- Single request, CONF_GAP = 0: pulse REQ[0] with TX_READY = 1 -> TRIG and GRANT = 4'b0001 3 cycles later, TRIG_ID = 0, ACCEPT_CNT = 1; a second request gives TRIG_ID = 1.
- Fairness: hold all four REQ rising simultaneously -> GRANT order 0001, 0010, 0100, 1000, SKIP_CNT = 0.
- Round-robin pointer: then REQ[2] and REQ[0] together -> GRANT 0001 first, then 0100.
- Skip: three REQ[1] edges while the engine sits in WAIT (TX_READY held 0) -> one trigger issued after ready, SKIP_CNT = 2.
- Gap: CONF_GAP = 10, back-to-back requests, TX_READY returns at cycle r -> next TRIG not before cycle r+12; check exact cycle.
- Timeout, ID wrap and clear:
  - Two TX_TIME_OUT pulses in WAIT -> TIMEOUT_CNT = 2, no extra TRIG.
  - Force the ID counter to 0x7FFFFFFF; ISSUE -> TRIG_ID = 0x7FFFFFFF, next TRIG_ID = 0.
  - ID_CLEAR coincident with ISSUE -> next TRIG_ID = 0.
- Async reset mid-WAIT:
  - Assert SYS_RST between clock edges -> outputs go to zero immediately, pending flags are lost.
  - After release, no TRIG appears without a new REQ edge.
- Masking: PORT_MASK = 4'b0100 with REQ[2] pulses -> no GRANT[2] and SKIP_CNT unchanged.
